spi_master_multi: RTL and testbench

SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

---
 rtl/spi_master_multi.sv | 250 +++++++++++++++++++++++++
 tb/tb_spi_master_multi.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_multi.sv
// -----------------------------------------------------------------------------
// spi_master_multi
//
// Memory-mapped SPI master with up to eight active-low chip selects.
//
// Register map (address[15:8] must equal ID, offset = address[7:0]):
//   0x00 CONFIG  RW   [0] enable, [1] cpol, [2] cpha, [4:3] length
//                     (0/1/2/3 = 8/16/24/32 bits), [10:8] csSelect,
//                     [16 +: CLOCK_WIDTH] clockScale (half-period = scale+1)
//   0x04 STATUS  RW1C [0] busy (read-only), [1] rxValid, [2] overrun
//   0x08 DATA         write starts a transfer, read returns the last RX word
//
// Ports:
//   clk, rst                   single clock, asynchronous active-low reset
//   peripheralEnable/_we/_oe   bus select and strobes
//   peripheralBus_address      [15:8] device ID, [7:0] register offset
//   peripheralBus_byteSelect   per-lane write enables
//   peripheralBus_dataWrite    write data
//   peripheralBus_dataRead     combinational read data (0 when not read)
//   peripheralBus_busy         always 0, no wait states
//   requestOutput              high while this device drives read data
//   spi_en                     pad output enable (= CONFIG.enable)
//   spi_clk, spi_mosi, spi_miso, spi_cs   SPI pins
// -----------------------------------------------------------------------------
module spi_master_multi #(
    parameter logic [7:0] ID          = 8'h01,
    parameter int         CLOCK_WIDTH = 8,
    parameter int         CS_COUNT    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                peripheralEnable,
    input  logic                peripheralBus_we,
    input  logic                peripheralBus_oe,
    output logic                peripheralBus_busy,
    input  logic [15:0]         peripheralBus_address,
    input  logic [3:0]          peripheralBus_byteSelect,
    input  logic [31:0]         peripheralBus_dataWrite,
    output logic [31:0]         peripheralBus_dataRead,
    output logic                requestOutput,
    output logic                spi_en,
    output logic                spi_clk,
    output logic                spi_mosi,
    input  logic                spi_miso,
    output logic [CS_COUNT-1:0] spi_cs
);

    localparam logic [31:0] SCALE_MASK  = 32'((33'd1 << CLOCK_WIDTH) - 33'd1);
    localparam logic [31:0] CONFIG_MASK = 32'h0000_071F | (SCALE_MASK << 16);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t                 state_reg, state_next;
    logic [31:0]            config_reg, config_next;
    logic [31:0]            tx_word_reg, tx_merge;
    logic [31:0]            tx_sr_reg, rx_sr_reg, rx_word_reg;
    logic                   rx_valid_reg, overrun_reg;
    logic                   sclk_reg, mosi_reg, cpol_reg, cpha_reg;
    logic [2:0]             cs_sel_reg;
    logic [CLOCK_WIDTH-1:0] scale_reg;
    logic [CLOCK_WIDTH:0]   cnt_reg;
    logic [5:0]             half_reg, last_half_reg;

    logic        selected, wr, rd, cfg_wr, sts_wr, data_wr, data_rd;
    logic        busy, start, phase_done;
    logic        lead_edge, trail_edge, xfer_done, sample_edge, shift_edge;
    logic        read_hit;
    logic [31:0] read_data;
    logic [7:0]  offset;

    assign selected = peripheralEnable && (peripheralBus_address[15:8] == ID);
    assign offset   = peripheralBus_address[7:0];
    assign wr       = selected && peripheralBus_we;
    assign rd       = selected && peripheralBus_oe;
    assign cfg_wr   = wr && (offset == 8'h00);
    assign sts_wr   = wr && (offset == 8'h04);
    assign data_wr  = wr && (offset == 8'h08);

    // Byte-lane merge for CONFIG and for the TX holding word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign config_next[8*gi +: 8] =
                (cfg_wr && peripheralBus_byteSelect[gi]) ?
                (peripheralBus_dataWrite[8*gi +: 8] & CONFIG_MASK[8*gi +: 8]) :
                config_reg[8*gi +: 8];
            assign tx_merge[8*gi +: 8] = peripheralBus_byteSelect[gi] ?
                peripheralBus_dataWrite[8*gi +: 8] : tx_word_reg[8*gi +: 8];
        end
    endgenerate

    assign busy       = (state_reg != IDLE);
    assign start      = data_wr && !busy && config_reg[0];
    assign phase_done = (cnt_reg == {1'b0, scale_reg});

    // Next-state logic. Edge strobes mark the clk edge on which spi_clk
    // changes: leading edges enter even SHIFT half-periods, trailing edges
    // odd ones. Leaving the last (odd) half-period needs no edge because
    // spi_clk is already back at cpol.
    always_comb begin
        state_next = state_reg;
        lead_edge  = 1'b0;
        trail_edge = 1'b0;
        xfer_done  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = SETUP;
            end
            SETUP: begin
                if (phase_done) begin
                    state_next = SHIFT;
                    lead_edge  = 1'b1;
                end
            end
            SHIFT: begin
                if (phase_done) begin
                    if (half_reg == last_half_reg) state_next = HOLD;
                    else if (half_reg[0])          lead_edge  = 1'b1;
                    else                           trail_edge = 1'b1;
                end
            end
            HOLD: begin
                if (phase_done) begin
                    state_next = IDLE;
                    xfer_done  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // Clearing enable mid-transfer abandons it without delivering data.
        if (busy && !config_next[0]) begin
            state_next = IDLE;
            lead_edge  = 1'b0;
            trail_edge = 1'b0;
            xfer_done  = 1'b0;
        end
    end

    assign sample_edge = cpha_reg ? trail_edge : lead_edge;
    assign shift_edge  = cpha_reg ? lead_edge  : trail_edge;

    // Combinational register read.
    always_comb begin
        read_hit  = 1'b0;
        read_data = '0;
        if (rd) begin
            case (offset)
                8'h00: begin read_hit = 1'b1; read_data = config_reg; end
                8'h04: begin
                    read_hit  = 1'b1;
                    read_data = {29'd0, overrun_reg, rx_valid_reg, busy};
                end
                8'h08: begin read_hit = 1'b1; read_data = rx_word_reg; end
                default: ;
            endcase
        end
    end

    assign data_rd                = read_hit && (offset == 8'h08);
    assign requestOutput          = read_hit && rst;
    assign peripheralBus_dataRead = (read_hit && rst) ? read_data : 32'd0;
    assign peripheralBus_busy     = 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            config_reg    <= '0;
            tx_word_reg   <= '0;
            tx_sr_reg     <= '0;
            rx_sr_reg     <= '0;
            rx_word_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            overrun_reg   <= 1'b0;
            sclk_reg      <= 1'b0;
            mosi_reg      <= 1'b0;
            cpol_reg      <= 1'b0;
            cpha_reg      <= 1'b0;
            cs_sel_reg    <= '0;
            scale_reg     <= '0;
            cnt_reg       <= '0;
            half_reg      <= '0;
            last_half_reg <= '0;
        end else begin
            state_reg  <= state_next;
            config_reg <= config_next;

            if (state_reg == IDLE || state_next != state_reg || phase_done)
                cnt_reg <= '0;
            else
                cnt_reg <= cnt_reg + 1'b1;

            if (state_reg != SHIFT)
                half_reg <= '0;
            else if (phase_done && state_next == SHIFT)
                half_reg <= half_reg + 6'd1;

            if (start) begin
                // Snapshot everything the transfer depends on so later
                // CONFIG writes cannot disturb it. TX is left-aligned so
                // bit 31 is always the next bit out.
                tx_word_reg   <= tx_merge;
                tx_sr_reg     <= tx_merge << {~config_reg[4:3], 3'b000};
                rx_sr_reg     <= '0;
                last_half_reg <= {config_reg[4:3], 4'hF};
                cs_sel_reg    <= config_reg[10:8];
                scale_reg     <= config_reg[16 +: CLOCK_WIDTH];
                cpol_reg      <= config_reg[1];
                cpha_reg      <= config_reg[2];
                sclk_reg      <= config_reg[1];
                if (!config_reg[2])
                    mosi_reg <= tx_merge[{config_reg[4:3], 3'b111}];
            end else begin
                if (lead_edge)  sclk_reg <= ~cpol_reg;
                if (trail_edge) sclk_reg <= cpol_reg;
                if (shift_edge) begin
                    tx_sr_reg <= {tx_sr_reg[30:0], 1'b0};
                    // cpha=0 already shows the MSB, so the next bit is [30].
                    mosi_reg  <= cpha_reg ? tx_sr_reg[31] : tx_sr_reg[30];
                end
                if (sample_edge) rx_sr_reg <= {rx_sr_reg[30:0], spi_miso};
            end

            if (xfer_done) rx_word_reg <= rx_sr_reg;

            // Completion outranks both clear sources so a word is never lost.
            if (xfer_done)
                rx_valid_reg <= 1'b1;
            else if ((sts_wr && peripheralBus_byteSelect[0] &&
                      peripheralBus_dataWrite[1]) || data_rd)
                rx_valid_reg <= 1'b0;

            if ((data_wr && busy) || (xfer_done && rx_valid_reg && !data_rd))
                overrun_reg <= 1'b1;
            else if (sts_wr && peripheralBus_byteSelect[0] &&
                     peripheralBus_dataWrite[2])
                overrun_reg <= 1'b0;
        end
    end

    assign spi_en   = config_reg[0];
    assign spi_clk  = (config_reg[0] && busy) ? sclk_reg : config_reg[1];
    assign spi_mosi = mosi_reg;

    generate
        for (gi = 0; gi < CS_COUNT; gi++) begin : g_cs
            assign spi_cs[gi] = !(config_reg[0] && busy && (cs_sel_reg == 3'(gi)));
        end
    endgenerate

endmodule

// File: tb/tb_spi_master_multi.sv
// -----------------------------------------------------------------------------
// tb_spi_master_multi
//
// Directed bench for spi_master_multi: one task per scenario, each with its
// own hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_spi_master_multi;

    localparam logic [15:0] A_CFG  = 16'h0100;
    localparam logic [15:0] A_STS  = 16'h0104;
    localparam logic [15:0] A_DATA = 16'h0108;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, we, oe;
    logic [15:0] addr;
    logic [3:0]  bsel;
    logic [31:0] wdata;
    logic        bus_busy;
    logic [31:0] rdata;
    logic        req_out;
    logic        spi_en, spi_clk, spi_mosi, spi_miso;
    logic [3:0]  spi_cs;
    logic        loopback, miso_val;

    int n_vec = 0;
    int n_err = 0;

    assign spi_miso = loopback ? spi_mosi : miso_val;

    always #5 clk = ~clk;

    spi_master_multi dut (
        .clk                      (clk),
        .rst                      (rst),
        .peripheralEnable         (en),
        .peripheralBus_we         (we),
        .peripheralBus_oe         (oe),
        .peripheralBus_busy       (bus_busy),
        .peripheralBus_address    (addr),
        .peripheralBus_byteSelect (bsel),
        .peripheralBus_dataWrite  (wdata),
        .peripheralBus_dataRead   (rdata),
        .requestOutput            (req_out),
        .spi_en                   (spi_en),
        .spi_clk                  (spi_clk),
        .spi_mosi                 (spi_mosi),
        .spi_miso                 (spi_miso),
        .spi_cs                   (spi_cs)
    );

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d,
                             input logic [3:0] bs);
        @(negedge clk);
        en = 1'b1; we = 1'b1; oe = 1'b0; addr = a; wdata = d; bsel = bs;
        @(posedge clk);
        #1;
        en = 1'b0; we = 1'b0; bsel = 4'h0;
        $display("WR  addr=%h data=%h be=%b", a, d, bs);
    endtask

    task automatic bus_read(input logic [15:0] a, input bit verbose,
                            output logic [31:0] d, output logic r);
        @(negedge clk);
        en = 1'b1; oe = 1'b1; we = 1'b0; addr = a;
        #1;
        d = rdata;
        r = req_out;
        @(posedge clk);
        #1;
        en = 1'b0; oe = 1'b0;
        if (verbose) $display("RD  addr=%h data=%h req=%b", a, d, r);
    endtask

    task automatic wait_idle();
        logic [31:0] d;
        logic        r;
        bit          ok = 0;
        for (int i = 0; i < 1000; i++) begin
            bus_read(A_STS, 0, d, r);
            if (!d[0]) begin ok = 1; break; end
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL wait_idle: busy still %b after 1000 polls, required 0", d[0]);
        end
    endtask

    // Observes one transfer on chip select cs_idx, sampling on negedges.
    task automatic watch(input int cs_idx, output int low_cyc, output int rises,
                         output int clk_low, output logic [31:0] bits,
                         output logic other_low);
        logic prev = spi_clk;
        bit   seen = 0;
        bit   ended = 0;
        low_cyc = 0; rises = 0; clk_low = 0; bits = '0; other_low = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++)
                if (j != cs_idx && !spi_cs[j]) other_low = 1'b1;
            if (!spi_cs[cs_idx]) begin
                seen = 1;
                low_cyc++;
                if (spi_clk && !prev) begin
                    rises++;
                    bits = {bits[30:0], spi_mosi};
                end
                if (!spi_clk) clk_low++;
            end else if (seen) begin
                ended = 1;
                break;
            end
            prev = spi_clk;
        end
        n_vec++;
        if (!ended) begin
            n_err++;
            $display("FAIL watch_end: cs[%0d] transfer seen=%0d ended=0, required ended=1",
                     cs_idx, seen);
        end
        $display("XFER cs=%0d low=%0d rises=%0d clk_low=%0d mosi=%h", cs_idx,
                 low_cyc, rises, clk_low, bits);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en = 1'b1; oe = 1'b1; we = 1'b0; addr = A_CFG; bsel = 4'h0; wdata = '0;
        loopback = 1'b1; miso_val = 1'b0;
        #12;
        n_vec++;
        if ({spi_en, spi_clk, spi_mosi, spi_cs, req_out, rdata} !== {1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_outputs: got en=%b clk=%b mosi=%b cs=%h req=%b rd=%h, required 0 0 0 f 0 0",
                     spi_en, spi_clk, spi_mosi, spi_cs, req_out, rdata);
        end
        n_vec++;
        if (bus_busy !== 1'b0) begin
            n_err++;
            $display("FAIL bus_busy: got %b required 0", bus_busy);
        end
        en = 1'b0; oe = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        begin
            logic [31:0] d; logic r;
            bus_read(A_CFG, 1, d, r);
            n_vec++;
            if (d !== 32'd0 || r !== 1'b1) begin
                n_err++;
                $display("FAIL reset_config: got %h req=%b required 00000000 req=1", d, r);
            end
            bus_read(A_STS, 1, d, r);
            n_vec++;
            if (d !== 32'd0) begin
                n_err++;
                $display("FAIL reset_status: got %h required 00000000", d);
            end
        end
    endtask

    task automatic test_mode0();
        int low, rises, clow; logic [31:0] bits; logic oth;
        logic [31:0] d; logic r;
        loopback = 1'b1;
        bus_write(A_CFG, 32'h0000_0001, 4'hF);
        bus_write(A_DATA, 32'h0000_00A5, 4'hF);
        watch(0, low, rises, clow, bits, oth);
        n_vec++;
        if (low !== 18) begin
            n_err++;
            $display("FAIL mode0_cs_low: got %0d cycles required 18", low);
        end
        n_vec++;
        if (rises !== 8) begin
            n_err++;
            $display("FAIL mode0_pulses: got %0d required 8", rises);
        end
        n_vec++;
        if (bits !== 32'h0000_00A5) begin
            n_err++;
            $display("FAIL mode0_mosi: got %h required 000000a5", bits);
        end
        bus_read(A_STS, 1, d, r);
        n_vec++;
        if (d !== 32'h2) begin
            n_err++;
            $display("FAIL mode0_status: got %h required 00000002", d);
        end
        bus_read(A_DATA, 1, d, r);
        n_vec++;
        if (d !== 32'h0000_00A5 || r !== 1'b1) begin
            n_err++;
            $display("FAIL mode0_rx: got %h req=%b required 000000a5 req=1", d, r);
        end
        bus_read(A_STS, 1, d, r);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL mode0_rxvalid_clear: got %h required 00000000", d);
        end
    endtask

    task automatic test_mode3();
        int low, rises, clow; logic [31:0] bits; logic oth;
        logic [31:0] d; logic r;
        loopback = 1'b0; miso_val = 1'b1;
        // cpol=1, cpha=1, 16-bit, cs2, scale 3
        bus_write(A_CFG, 32'h0003_020F, 4'hF);
        n_vec++;
        if (spi_clk !== 1'b1) begin
            n_err++;
            $display("FAIL mode3_idle_clk: got %b required 1", spi_clk);
        end
        bus_write(A_DATA, 32'h0000_1234, 4'hF);
        watch(2, low, rises, clow, bits, oth);
        n_vec++;
        if (low !== 136) begin
            n_err++;
            $display("FAIL mode3_cs_low: got %0d required 136", low);
        end
        n_vec++;
        if (clow !== 64 || rises !== 16) begin
            n_err++;
            $display("FAIL mode3_clk_shape: got low=%0d rises=%0d required 64 16", clow, rises);
        end
        n_vec++;
        if (oth !== 1'b0) begin
            n_err++;
            $display("FAIL mode3_other_cs: got %b required 0", oth);
        end
        bus_read(A_DATA, 1, d, r);
        n_vec++;
        if (d !== 32'h0000_FFFF) begin
            n_err++;
            $display("FAIL mode3_rx: got %h required 0000ffff", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic r;
        loopback = 1'b1;
        bus_write(A_CFG, 32'h0000_0001, 4'hF);
        bus_write(A_STS, 32'h0000_0006, 4'hF);
        bus_write(A_DATA, 32'h0000_003C, 4'hF);
        bus_write(A_DATA, 32'h0000_00C3, 4'hF);
        bus_read(A_STS, 1, d, r);
        n_vec++;
        if (d !== 32'h5) begin
            n_err++;
            $display("FAIL b2b_status_busy: got %h required 00000005", d);
        end
        wait_idle();
        bus_read(A_STS, 1, d, r);
        n_vec++;
        if (d !== 32'h6) begin
            n_err++;
            $display("FAIL b2b_status_done: got %h required 00000006", d);
        end
        bus_write(A_STS, 32'h0000_0004, 4'hF);
        bus_read(A_STS, 1, d, r);
        n_vec++;
        if (d !== 32'h2) begin
            n_err++;
            $display("FAIL b2b_overrun_clear: got %h required 00000002", d);
        end
        bus_read(A_DATA, 1, d, r);
        n_vec++;
        if (d !== 32'h0000_003C) begin
            n_err++;
            $display("FAIL b2b_rx: got %h required 0000003c", d);
        end
    endtask

    task automatic test_double_32();
        logic [31:0] d; logic r;
        loopback = 1'b1;
        bus_write(A_STS, 32'h0000_0006, 4'hF);
        bus_write(A_CFG, 32'h0000_0019, 4'hF);
        bus_write(A_DATA, 32'hDEAD_BEEF, 4'hF);
        wait_idle();
        bus_write(A_DATA, 32'h1234_5678, 4'hF);
        wait_idle();
        bus_read(A_STS, 1, d, r);
        n_vec++;
        if (d !== 32'h6) begin
            n_err++;
            $display("FAIL dbl32_status: got %h required 00000006", d);
        end
        bus_read(A_DATA, 1, d, r);
        n_vec++;
        if (d !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL dbl32_rx: got %h required 12345678", d);
        end
    endtask

    task automatic test_abort();
        logic [31:0] d; logic r;
        logic prev;
        int   rises = 0;
        bit   reached = 0;
        loopback = 1'b1;
        bus_write(A_STS, 32'h0000_0006, 4'hF);
        bus_write(A_CFG, 32'h0000_0001, 4'hF);
        bus_write(A_DATA, 32'h0000_00FF, 4'hF);
        prev = spi_clk;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (spi_clk && !prev) rises++;
            prev = spi_clk;
            if (rises == 4) begin reached = 1; break; end
        end
        n_vec++;
        if (!reached) begin
            n_err++;
            $display("FAIL abort_reach_bit3: got %0d pulses required 4", rises);
        end
        bus_write(A_CFG, 32'h0000_0000, 4'hF);
        n_vec++;
        if (spi_cs !== 4'hF || spi_clk !== 1'b0 || spi_en !== 1'b0) begin
            n_err++;
            $display("FAIL abort_pins: got cs=%h clk=%b en=%b required f 0 0", spi_cs, spi_clk, spi_en);
        end
        bus_read(A_STS, 1, d, r);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL abort_status: got %h required 00000000", d);
        end
        bus_write(A_DATA, 32'h0000_0055, 4'hF);
        repeat (20) @(negedge clk);
        bus_read(A_STS, 1, d, r);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL abort_disabled_write: got %h required 00000000", d);
        end

        // Asynchronous reset in the middle of a transfer.
        bus_write(A_CFG, 32'h0000_0003, 4'hF);
        bus_write(A_DATA, 32'h0000_00FF, 4'hF);
        repeat (5) @(posedge clk);
        #3;
        n_vec++;
        if (spi_mosi !== 1'b1 || spi_cs[0] !== 1'b0) begin
            n_err++;
            $display("FAIL pre_reset_active: got mosi=%b cs0=%b required 1 0", spi_mosi, spi_cs[0]);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if ({spi_en, spi_clk, spi_mosi, spi_cs} !== {1'b0, 1'b0, 1'b0, 4'hF}) begin
            n_err++;
            $display("FAIL async_reset: got en=%b clk=%b mosi=%b cs=%h required 0 0 0 f",
                     spi_en, spi_clk, spi_mosi, spi_cs);
        end
        @(negedge clk);
        rst = 1'b1;
        bus_read(A_CFG, 1, d, r);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL post_reset_config: got %h required 00000000", d);
        end
        bus_read(A_DATA, 1, d, r);
        n_vec++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL post_reset_rx: got %h required 00000000", d);
        end
        bus_write(A_CFG, 32'h0000_0001, 4'hF);
        bus_write(A_DATA, 32'h0000_005A, 4'hF);
        wait_idle();
        bus_read(A_DATA, 1, d, r);
        n_vec++;
        if (d !== 32'h0000_005A) begin
            n_err++;
            $display("FAIL post_reset_xfer: got %h required 0000005a", d);
        end
    endtask

    task automatic test_decode();
        logic [31:0] d; logic r;
        bus_write(A_CFG, 32'h0000_0000, 4'hF);
        bus_write(A_CFG, 32'hFFFF_FFFF, 4'b0100);
        bus_read(A_CFG, 1, d, r);
        n_vec++;
        if (d !== 32'h00FF_0000) begin
            n_err++;
            $display("FAIL bytelane_config: got %h required 00ff0000", d);
        end
        bus_write(A_CFG, 32'hFFFF_FFFF, 4'hF);
        bus_read(A_CFG, 1, d, r);
        n_vec++;
        if (d !== 32'h00FF_071F) begin
            n_err++;
            $display("FAIL config_mask: got %h required 00ff071f", d);
        end
        bus_write(A_CFG, 32'h0001_0000, 4'hF);
        bus_read(16'h010C, 1, d, r);
        n_vec++;
        if (d !== 32'h0 || r !== 1'b0) begin
            n_err++;
            $display("FAIL bad_offset: got %h req=%b required 00000000 req=0", d, r);
        end
        bus_write(16'h0200, 32'hFFFF_FFFF, 4'hF);
        bus_read(16'h0200, 1, d, r);
        n_vec++;
        if (d !== 32'h0 || r !== 1'b0) begin
            n_err++;
            $display("FAIL bad_id: got %h req=%b required 00000000 req=0", d, r);
        end
        bus_read(A_CFG, 1, d, r);
        n_vec++;
        if (d !== 32'h0001_0000) begin
            n_err++;
            $display("FAIL bad_id_no_write: got %h required 00010000", d);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_back_to_back();
        test_double_32();
        test_abort();
        test_decode();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
